// File: rtl/voice_mixer_pwm.sv
// Multi-voice mixer with volume shift, saturation and glitch-free PWM audio output.
// Optional build macro MIXER_DITHER_EN adds LFSR +1 LSB dither on the duty value.
module voice_mixer_pwm #(
   parameter int AM_WIDTH  = 8,
   parameter int VOICES    = 4,
   parameter int PWM_WIDTH = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [VOICES*AM_WIDTH-1:0]   am_bus,
   input  logic [2:0]                   vol,
   output logic                         pwm_out,
   output logic                         sample_strobe,
   output logic                         clip
);

   localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int ACC_W = AM_WIDTH + $clog2(VOICES);
   localparam int SHIFT = PWM_WIDTH - AM_WIDTH;
   localparam int S_W   = ACC_W + SHIFT;

   localparam logic [PWM_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [PWM_WIDTH-1:0] MIDSCALE = {1'b1, {(PWM_WIDTH-1){1'b0}}};
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(VOICES - 1);
   localparam logic signed [S_W-1:0] SAT_HI  = S_W'((64'sd1 <<< (PWM_WIDTH - 1)) - 64'sd1);
   localparam logic signed [S_W-1:0] SAT_LO  = ~SAT_HI;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_SCALE} state_t;

   state_t                        state_q, state_d;
   logic [PWM_WIDTH-1:0]          cnt_q;
   logic [PWM_WIDTH-1:0]          duty_q;
   logic [PWM_WIDTH-1:0]          duty_next_q, duty_next_d;
   logic                          clip_next_q, clip_next_d;
   logic                          clip_q;
   logic                          pwm_q;
   logic                          strobe_q;
   logic                          pending_q, pending_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic signed [ACC_W-1:0]       acc_q, acc_d;
   logic [VOICES*AM_WIDTH-1:0]    am_q, am_d;
   logic [2:0]                    vol_q, vol_d;

   logic                          wrap;
   logic signed [AM_WIDTH-1:0]    voice_w [VOICES];
   logic signed [S_W-1:0]         widened_w, scaled_w;
   logic signed [PWM_WIDTH-1:0]   sat_w;
   logic                          sat_hit_w;
   logic [PWM_WIDTH-1:0]          duty_calc_w, duty_out_w;

   assign wrap = (cnt_q == CNT_MAX);

   genvar gi;
   generate
      for (gi = 0; gi < VOICES; gi++) begin : g_voice
         assign voice_w[gi] = am_q[gi*AM_WIDTH +: AM_WIDTH];
      end
   endgenerate

   // Widen before shifting so the left shift never drops accumulator bits.
   always_comb begin
      widened_w = S_W'(acc_q) <<< SHIFT;
      scaled_w  = widened_w >>> vol_q;
      sat_hit_w = 1'b0;
      sat_w     = scaled_w[PWM_WIDTH-1:0];
      if (scaled_w > SAT_HI) begin
         sat_w     = SAT_HI[PWM_WIDTH-1:0];
         sat_hit_w = 1'b1;
      end else if (scaled_w < SAT_LO) begin
         sat_w     = SAT_LO[PWM_WIDTH-1:0];
         sat_hit_w = 1'b1;
      end
      duty_calc_w = {~sat_w[PWM_WIDTH-1], sat_w[PWM_WIDTH-2:0]};
   end

`ifdef MIXER_DITHER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= 16'hACE1;
      end else if (wrap) begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   always_comb begin
      duty_out_w = duty_calc_w;
      if (lfsr_q[0] && (duty_calc_w != CNT_MAX)) begin
         duty_out_w = duty_calc_w + 1'b1;
      end
   end
`else
   assign duty_out_w = duty_calc_w;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      am_d        = am_q;
      vol_d       = vol_q;
      duty_next_d = duty_next_q;
      clip_next_d = clip_next_q;
      pending_d   = pending_q;
      if (wrap) begin
         pending_d = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (wrap) begin
               am_d    = am_bus;
               vol_d   = vol;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            acc_d = acc_q + ACC_W'(voice_w[idx_q]);
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = S_SCALE;
            end
         end
         S_SCALE: begin
            duty_next_d = duty_out_w;
            clip_next_d = sat_hit_w;
            pending_d   = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // pending_q holds back the very first wrap so the first strobe lands on the second wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         duty_q      <= MIDSCALE;
         duty_next_q <= MIDSCALE;
         clip_next_q <= 1'b0;
         clip_q      <= 1'b0;
         pwm_q       <= 1'b0;
         strobe_q    <= 1'b0;
         pending_q   <= 1'b0;
         idx_q       <= '0;
         acc_q       <= '0;
         am_q        <= '0;
         vol_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_q + 1'b1;
         duty_next_q <= duty_next_d;
         clip_next_q <= clip_next_d;
         pending_q   <= pending_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         am_q        <= am_d;
         vol_q       <= vol_d;
         pwm_q       <= (cnt_q < duty_q);
         strobe_q    <= wrap && pending_q;
         if (wrap && pending_q) begin
            duty_q <= duty_next_q;
            clip_q <= clip_next_q;
         end
      end
   end

   assign pwm_out       = pwm_q;
   assign sample_strobe = strobe_q;
   assign clip          = clip_q;

endmodule

// File: tb/tb_voice_mixer_pwm.sv
// Randomized scoreboard bench for voice_mixer_pwm (default build, dither disabled).
module tb_voice_mixer_pwm;

   localparam int AW     = 8;
   localparam int NV     = 4;
   localparam int PW     = 10;
   localparam int PERIOD = 1 << PW;
   localparam int HALF   = 1 << (PW - 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NV*AW-1:0]     am_bus = '0;
   logic [2:0]           vol = '0;
   logic                 pwm_out, sample_strobe, clip;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int duty;
      bit clip;
   } exp_t;

   exp_t exp_q[$];
   int   tb_cyc;

   always #5 clk = ~clk;

   voice_mixer_pwm #(.AM_WIDTH(AW), .VOICES(NV), .PWM_WIDTH(PW)) dut (
      .clk           (clk),
      .rst           (rst),
      .am_bus        (am_bus),
      .vol           (vol),
      .pwm_out       (pwm_out),
      .sample_strobe (sample_strobe),
      .clip          (clip)
   );

   // Reference: sum the voices as integers, scale to PWM range, attenuate, clamp, offset.
   function automatic exp_t model(input logic [NV*AW-1:0] bus, input logic [2:0] v);
      int   sum;
      int   s;
      exp_t e;
      sum = 0;
      for (int i = 0; i < NV; i++) sum += int'($signed(bus[i*AW +: AW]));
      s = (sum * (1 << (PW - AW))) >>> v;
      e.clip = (s > HALF - 1) || (s < -HALF);
      if (s > HALF - 1) s = HALF - 1;
      if (s < -HALF)    s = -HALF;
      e.duty = s + HALF;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, tb_cyc);
      end
   endtask

   // Cycle count since reset release; every wrap cycle the snapshot's expected result is queued.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         tb_cyc <= 0;
         exp_q.delete();
      end else begin
         if (tb_cyc % PERIOD == PERIOD - 1) exp_q.push_back(model(am_bus, vol));
         tb_cyc <= tb_cyc + 1;
      end
   end

   exp_t cur;
   bit   active;
   int   hi_cnt, len, pre_hi;

   always @(negedge clk) begin
      if (!rst) begin
         active = 1'b0;
         hi_cnt = 0;
         len    = 0;
         pre_hi = 0;
      end else begin
         if (tb_cyc >= 1 && tb_cyc <= 2 * PERIOD) pre_hi += int'(pwm_out);
         if (tb_cyc == PERIOD || tb_cyc == 2 * PERIOD) check("midscale_pre", pre_hi, tb_cyc / 2);
         if (tb_cyc == 2 * PERIOD) check("first_strobe", int'(sample_strobe), 1);
         if (active) begin
            hi_cnt += int'(pwm_out);
            len++;
         end
         if (sample_strobe) begin
            if (active) begin
               check("strobe_spacing", len, PERIOD);
               check("duty_high", hi_cnt, cur.duty);
               $display("period cyc=%0d high=%0d exp_duty=%0d clip=%0d", tb_cyc, hi_cnt, cur.duty, cur.clip);
            end else if (tb_cyc != 2 * PERIOD) begin
               check("early_strobe_cycle", tb_cyc, 2 * PERIOD);
            end
            if (exp_q.size() == 0) begin
               check("strobe_without_snapshot", 1, 0);
               active = 1'b0;
            end else begin
               cur = exp_q.pop_front();
               check("clip", int'(clip), int'(cur.clip));
               active = 1'b1;
            end
            hi_cnt = 0;
            len    = 0;
         end else if (active && len > PERIOD) begin
            check("missing_strobe_len", len, PERIOD);
            active = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_to(input int target);
      do step(); while (tb_cyc < target);
   endtask

   task automatic wait_phase(input int ph);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((tb_cyc % PERIOD != ph) && (n <= PERIOD + 1));
      if (n > PERIOD + 1) check("wait_phase_timeout", n, PERIOD);
   endtask

   task automatic hold_periods(input int n);
      wait_to(tb_cyc + n * PERIOD);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_pwm", int'(pwm_out), 0);
      check("reset_strobe", int'(sample_strobe), 0);
      check("reset_clip", int'(clip), 0);
      step();
      rst = 1'b1;

      // Silence, then directed patterns: single voice, full-scale clip, negative with attenuation.
      wait_to(3 * PERIOD + 10);
      wait_phase(500);
      am_bus = {8'sd0, 8'sd0, 8'sd0, 8'sd64};
      hold_periods(2);
      am_bus = {4{8'h7F}};
      hold_periods(2);
      am_bus = {4{8'h80}};
      vol    = 3'd2;
      hold_periods(2);

      // Changes land mid-period at random phases; the snapshot alone decides each period.
      wait_phase(300);
      am_bus = {8'sd10, -8'sd20, 8'sd30, -8'sd5};
      vol    = 3'd1;
      for (int i = 0; i < 16; i++) begin
         wait_phase($urandom_range(0, PERIOD - 1));
         am_bus = $urandom;
         vol    = 3'($urandom_range(0, 7));
      end
      hold_periods(1);

      // Drive into clipping, then reset while the accumulator is running.
      am_bus = {4{8'h7F}};
      vol    = 3'd0;
      hold_periods(2);
      wait_phase(1);
      check("pre_reset_clip", int'(clip), 1);
      rst = 1'b0;
      @(negedge clk);
      check("midreset_pwm", int'(pwm_out), 0);
      check("midreset_strobe", int'(sample_strobe), 0);
      check("midreset_clip", int'(clip), 0);
      repeat (4) step();
      rst = 1'b1;
      wait_to(3 * PERIOD + 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
